// File: rtl/conv_tile_row_feeder.sv
// Assembles kx rows of (Pix + kx/2) pixels per tile column from a row-major pixel stream,
// derives west padding from the previous tile, and holds each tile until the consumer releases it.
module conv_tile_row_feeder #(
   parameter int kx    = 3,
   parameter int Pix   = 3,
   parameter int RES   = 8,
   parameter int IMG_W = 6
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [RES-1:0]                           in_data,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic                                     tile_consumed,
   output logic [kx-1:0][Pix+kx/2-1:0][RES-1:0]     pixel_row,
   output logic [kx-1:0][kx/2-1:0][RES-1:0]         west_paddings,
   output logic                                     pixel_ready,
   output logic [$clog2(IMG_W/Pix)-1:0]             tile_col
);
   // state   | meaning
   // FILL    | accepting beats into pixel_row, row/col counters advance
   // PRESENT | tile complete, outputs held until tile_consumed

   localparam int HALO    = kx / 2;
   localparam int ROW_W   = Pix + HALO;
   localparam int N_TILES = IMG_W / Pix;
   localparam int CW      = (ROW_W > 1) ? $clog2(ROW_W) : 1;
   localparam int RW      = (kx > 1) ? $clog2(kx) : 1;
   localparam int TW      = $clog2(N_TILES);

   typedef enum logic {FILL, PRESENT} state_t;

   state_t                                state_q, state_d;
   logic [RW-1:0]                         row_q, row_d;
   logic [CW-1:0]                         col_q, col_d;
   logic [TW-1:0]                         tile_col_q, tile_col_d;
   logic [kx-1:0][ROW_W-1:0][RES-1:0]     pix_q, pix_d;
   logic [kx-1:0][HALO-1:0][RES-1:0]      west_q, west_d;
   logic                                  in_ready_q, in_ready_d;
   logic                                  pixel_ready_q, pixel_ready_d;

   logic          last_tile;
   logic [CW-1:0] last_col;
   logic          accept;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      tile_col_d = tile_col_q;
      pix_d      = pix_q;
      west_d     = west_q;
      last_tile  = (tile_col_q == TW'(N_TILES - 1));
      last_col   = last_tile ? CW'(Pix - 1) : CW'(ROW_W - 1);
      accept     = in_valid && in_ready_q;

      case (state_q)
         FILL: begin
            if (accept) begin
               pix_d[row_q][col_q] = in_data;
               if (col_q == last_col) begin
                  col_d = '0;
                  // the rightmost tile has no east neighbour, so its halo is zero
                  if (last_tile) begin
                     for (int j = Pix; j < ROW_W; j++) pix_d[row_q][j] = '0;
                  end
                  if (row_q == RW'(kx - 1)) begin
                     row_d   = '0;
                     state_d = PRESENT;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         PRESENT: begin
            if (tile_consumed) begin
               state_d = FILL;
               row_d   = '0;
               col_d   = '0;
               if (last_tile) begin
                  west_d     = '0;
                  tile_col_d = '0;
               end else begin
                  for (int r = 0; r < kx; r++) begin
                     for (int j = 0; j < HALO; j++) begin
                        west_d[r][j] = pix_q[r][Pix-HALO+j];
                     end
                  end
                  tile_col_d = tile_col_q + 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase

      // registered so both flags are low while reset is asserted
      in_ready_d    = (state_d == FILL);
      pixel_ready_d = (state_d == PRESENT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FILL;
         row_q         <= '0;
         col_q         <= '0;
         tile_col_q    <= '0;
         pix_q         <= '0;
         west_q        <= '0;
         in_ready_q    <= 1'b0;
         pixel_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         tile_col_q    <= tile_col_d;
         pix_q         <= pix_d;
         west_q        <= west_d;
         in_ready_q    <= in_ready_d;
         pixel_ready_q <= pixel_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign pixel_ready   = pixel_ready_q;
   assign pixel_row     = pix_q;
   assign west_paddings = west_q;
   assign tile_col      = tile_col_q;

endmodule

// File: tb/tb_conv_tile_row_feeder.sv
// Bench for conv_tile_row_feeder: a driver streams tiles and queues the expected tile,
// a monitor pops and compares whenever the DUT presents a tile.
module tb_conv_tile_row_feeder;
   localparam int KX    = 3;
   localparam int PIX   = 3;
   localparam int RES   = 8;
   localparam int IMG_W = 6;
   localparam int HALO  = KX / 2;
   localparam int ROW_W = PIX + HALO;
   localparam int NT    = IMG_W / PIX;
   localparam int TW    = $clog2(NT);

   typedef logic [KX-1:0][ROW_W-1:0][RES-1:0] rows_t;
   typedef logic [KX-1:0][HALO-1:0][RES-1:0]  west_t;
   typedef struct {
      rows_t rows;
      west_t west;
      int    col;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [RES-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic           tile_consumed;
   rows_t          pixel_row;
   west_t          west_paddings;
   logic           pixel_ready;
   logic [TW-1:0]  tile_col;

   conv_tile_row_feeder #(.kx(KX), .Pix(PIX), .RES(RES), .IMG_W(IMG_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .tile_consumed (tile_consumed),
      .pixel_row     (pixel_row),
      .west_paddings (west_paddings),
      .pixel_ready   (pixel_ready),
      .tile_col      (tile_col)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_hs = -1;
   exp_t q[$];
   int   mt = 0;
   rows_t prev_rows = '0;
   rows_t last_rows = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic abort(input string name);
      total++;
      bad++;
      $display("FAIL %s timed out (t=%0t)", name, $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "bench stopped");
   endtask

   // monitor
   initial begin : monitor
      exp_t cur;
      bit   have = 0;
      bit   prev_pr = 0;
      forever begin
         @(negedge clk);
         if (rst_n && pixel_ready && !prev_pr) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tile actual=presented required=none");
               have = 0;
            end else begin
               cur  = q.pop_front();
               have = 1;
               chk("present_latency", 64'(cyc), 64'(last_hs));
            end
         end
         if (rst_n && pixel_ready && have) begin
            for (int r = 0; r < KX; r++) begin
               chk($sformatf("pixel_row[%0d]", r), 64'(pixel_row[r]), 64'(cur.rows[r]));
               chk($sformatf("west[%0d]", r), 64'(west_paddings[r]), 64'(cur.west[r]));
            end
            chk("tile_col_present", 64'(tile_col), 64'(cur.col));
            chk("in_ready_present", 64'(in_ready), 64'd0);
         end
         if (rst_n && !pixel_ready && prev_pr) chk("in_ready_after_release", 64'(in_ready), 64'd1);
         prev_pr = rst_n ? pixel_ready : 1'b0;
      end
   end

   task automatic send_beat(input logic [RES-1:0] d);
      int n = 0;
      bit hs = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!hs) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (n > 200) abort("send_beat");
      end
      last_hs  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n, input bit pulse);
      repeat (n) begin
         tile_consumed = pulse && ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1;
         tile_consumed = 1'b0;
      end
   endtask

   // mode 0: contiguous beats base+1..; 1: valid every other cycle; 2: random gaps + stray tile_consumed
   task automatic run_tile(input int mode, input int base);
      int beats;
      int n = 0;
      logic [RES-1:0] d[$];
      exp_t e;
      beats = (mt == NT - 1) ? PIX : ROW_W;
      for (int i = 0; i < KX * beats; i++)
         d.push_back(mode == 0 ? RES'(base + i + 1) : RES'($urandom));
      e.rows = '0;
      for (int r = 0; r < KX; r++)
         for (int c = 0; c < beats; c++) e.rows[r][c] = d[r*beats + c];
      e.west = '0;
      if (mt != 0)
         for (int r = 0; r < KX; r++)
            for (int j = 0; j < HALO; j++) e.west[r][j] = prev_rows[r][PIX-HALO+j];
      e.col = mt;
      q.push_back(e);
      last_rows = e.rows;
      for (int i = 0; i < d.size(); i++) begin
         if (mode == 1 && i > 0) idle(1, 1'b0);
         if (mode == 2) idle($urandom_range(0, 2), 1'b1);
         send_beat(d[i]);
      end
      do begin
         @(negedge clk);
         n++;
      end while (!pixel_ready && n < 50);
      if (!pixel_ready) abort("wait_pixel_ready");
   endtask

   task automatic release_tile(input int hold, input int extra_valid);
      @(posedge clk);
      #1;
      repeat (extra_valid) begin
         in_valid = 1'b1;
         in_data  = RES'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid      = 1'b0;
      tile_consumed = 1'b1;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      tile_consumed = 1'b0;
      prev_rows = last_rows;
      mt = (mt + 1) % NT;
      chk("tile_col_after_release", 64'(tile_col), 64'(mt));
      chk("pixel_ready_after_release", 64'(pixel_ready), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pixel_ready"}, 64'(pixel_ready), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_tile_col"}, 64'(tile_col), 64'd0);
      for (int r = 0; r < KX; r++) begin
         chk($sformatf("%s_pixel_row[%0d]", tag, r), 64'(pixel_row[r]), 64'd0);
         chk($sformatf("%s_west[%0d]", tag, r), 64'(west_paddings[r]), 64'd0);
      end
   endtask

   initial begin : driver
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      tile_consumed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_tile(0, 0);       // tile 0: beats 1..12
      release_tile(1, 5);   // in_valid ignored while presenting
      run_tile(0, 20);      // last tile: beats 21..29
      release_tile(1, 0);   // wrap back to tile 0
      run_tile(1, 0);
      release_tile(2, 0);
      run_tile(2, 0);
      release_tile(1, 2);

      // reset in the middle of a fill; partial tile must never be presented
      for (int i = 0; i < 7; i++) send_beat(RES'($urandom));
      rst_n = 1'b0;
      #2;
      check_reset_outputs("midfill_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      mt        = 0;
      prev_rows = '0;
      run_tile(0, 100);
      release_tile(1, 0);

      for (int k = 0; k < 8; k++) begin
         run_tile($urandom_range(1, 2), 0);
         release_tile($urandom_range(1, 2), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      abort("global_watchdog");
   end

endmodule
